// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte requesters,
// with launch, busy tracking, per-requester done pulses and a busy-start watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      transmit,
    output logic [DATA_W-1:0]         TxData,
    input  logic                      busy,
    output logic [ID_W-1:0]           active_id,
    output logic                      arb_busy,
    output logic                      timeout_err
);
    localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_START, S_WAIT_END} state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_last_id;
    logic [TW-1:0]   r_timer;
    logic [ID_W-1:0] w_sel;
    logic            w_go;

    // Scan downward so the requester closest after r_last_id is the last writer and wins.
    always_comb begin
        logic [ID_W-1:0] v_idx;
        v_idx = '0;
        w_sel = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = ID_W'((int'(r_last_id) + k) % NUM_REQ);
            if (req[v_idx]) w_sel = v_idx;
        end
        w_go = |req && !busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_last_id   <= ID_W'(NUM_REQ - 1);
            r_timer     <= '0;
            transmit    <= 1'b0;
            TxData      <= '0;
            grant       <= '0;
            done        <= '0;
            active_id   <= '0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            transmit    <= 1'b0;
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_state   <= S_LAUNCH;
                    transmit  <= 1'b1;
                    TxData    <= req_data[w_sel*DATA_W +: DATA_W];
                    grant     <= NUM_REQ'(1) << w_sel;
                    active_id <= w_sel;
                    r_last_id <= w_sel;
                    arb_busy  <= 1'b1;
                end
                S_LAUNCH: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: if (busy) begin
                    r_state <= S_WAIT_END;
                end else if (r_timer == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    r_state     <= S_IDLE;
                    arb_busy    <= 1'b0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
                S_WAIT_END: if (!busy) begin
                    done     <= NUM_REQ'(1) << active_id;
                    r_state  <= S_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-level model, UART transmitter emulation and directed
// scenarios for the round-robin UART transmit arbiter.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int DW  = 8;
    localparam int BT  = 16;
    localparam int TXL = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            busy = 1'b0;
    logic [N-1:0]    grant, done;
    logic            transmit, arb_busy, timeout_err;
    logic [DW-1:0]   TxData;
    logic [IW-1:0]   active_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant), .done(done),
        .transmit(transmit), .TxData(TxData), .busy(busy), .active_id(active_id),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    int errs = 0, checks = 0, cyc = 0;

    // model: owner of the transmitter and how far its transfer has progressed
    int            m_owner = -1, m_age = 0, m_last = N - 1;
    bit            m_started = 0;
    logic [N-1:0]  e_grant = '0, e_done = '0;
    logic          e_tx = 0, e_arb = 0, e_to = 0;
    logic [DW-1:0] e_data = '0;
    logic [IW-1:0] e_id = '0;

    int g_log[$], gd_log[$], id_log[$], g_cyc[$], d_log[$], d_cyc[$], rx_q[$];
    int tx_cyc = 0, to_cyc = 0, to_cnt = 0, em_cnt = 0, em_byte = 0;
    bit tx_en = 1;
    logic [N-1:0] keep = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = (v << 8) | 64'(q[i] & 8'hff);
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_age = 0; m_started = 0;
        e_grant = '0; e_done = '0; e_tx = 0; e_to = 0; e_arb = 0; e_data = '0; e_id = '0;
    endtask

    task automatic model_step();
        e_grant = '0; e_done = '0; e_tx = 0; e_to = 0;
        if (!reset) model_reset();
        else if (m_owner < 0) begin
            if (req != 0 && !busy) begin
                for (int k = 1; k <= N; k++)
                    if (m_owner < 0 && ((int'(req) >> ((m_last + k) % N)) & 1) == 1) m_owner = (m_last + k) % N;
                m_last = m_owner; m_age = 0; m_started = 0;
                e_grant = N'(1 << m_owner); e_tx = 1;
                e_data = DW'(req_data >> (m_owner * DW)); e_id = IW'(m_owner);
            end
        end else if (m_age == 0) m_age = 1;
        else if (!m_started) begin
            if (busy) m_started = 1;
            else if (m_age == BT) begin e_to = 1; m_owner = -1; end
            else m_age++;
        end else if (!busy) begin
            e_done = N'(1 << m_owner); m_owner = -1;
        end
        e_arb = m_owner >= 0;
    endtask

    task automatic check();
        chk("grant", 64'(grant), 64'(e_grant));
        chk("done", 64'(done), 64'(e_done));
        chk("transmit", 64'(transmit), 64'(e_tx));
        chk("TxData", 64'(TxData), 64'(e_data));
        chk("active_id", 64'(active_id), 64'(e_id));
        chk("arb_busy", 64'(arb_busy), 64'(e_arb));
        chk("timeout_err", 64'(timeout_err), 64'(e_to));
        chk("tx_while_busy", 64'(transmit & busy), 64'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check();
        if (grant != 0) begin
            g_log.push_back(int'(grant)); gd_log.push_back(int'(TxData));
            id_log.push_back(int'(active_id)); g_cyc.push_back(cyc);
        end
        if (done != 0) begin d_log.push_back(int'(done)); d_cyc.push_back(cyc); end
        if (transmit) tx_cyc = cyc;
        if (timeout_err) begin to_cyc = cyc; to_cnt++; end
        // transmitter emulation: busy rises two cycles after transmit and lasts TXL cycles
        if (!reset) em_cnt = 0;
        else if (transmit && tx_en) begin em_cnt = TXL + 2; em_byte = int'(TxData); end
        else if (em_cnt > 0) begin
            em_cnt--;
            if (em_cnt == 0) rx_q.push_back(em_byte);
        end
        busy = em_cnt >= 1 && em_cnt <= TXL;
        req = req & ~(grant & ~keep);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        g_log.delete(); gd_log.delete(); id_log.delete(); g_cyc.delete();
        d_log.delete(); d_cyc.delete(); rx_q.delete(); to_cnt = 0;
    endtask

    initial begin
        int n;
        run(2);
        chk("rst_arb_busy", 64'(arb_busy), 0);
        chk("rst_TxData", 64'(TxData), 0);
        chk("rst_grant", 64'(grant), 0);
        reset = 1'b1;

        // single transfer
        req_data = 32'h0000_00A5; req = 4'b0001;
        run(15);
        chk("t1_grants", pack(g_log), 64'h01);
        chk("t1_txdata", pack(gd_log), 64'hA5);
        chk("t1_rx", pack(rx_q), 64'hA5);
        chk("t1_done", pack(d_log), 64'h01);
        chk("t1_done_after_launch", 64'(d_cyc.size() > 0 ? d_cyc[0] - g_cyc[0] : -1), 64'(TXL + 3));

        // simultaneous requests from a fresh reset
        reset = 1'b0; model_reset(); run(1); reset = 1'b1; clr();
        req_data = 32'h4433_2211; req = 4'b1111;
        run(45);
        chk("t2_grants", pack(g_log), 64'h01020408);
        chk("t2_rx", pack(rx_q), 64'h11223344);
        chk("t2_done", pack(d_log), 64'h01020408);
        chk("t2_spacing", 64'(g_cyc.size() == 4 ? g_cyc[1] - g_cyc[0] : -1), 64'(TXL + 4));

        // fairness between two persistent requesters
        clr();
        keep = 4'b0101; req_data = 32'h00C3_005A; req = 4'b0101;
        n = 0;
        while (g_log.size() < 6 && n < 100) begin tick(); n++; end
        keep = '0; req = '0;
        run(12);
        chk("t3_grant_count", 64'(g_log.size()), 6);
        chk("t3_grants", pack(g_log), 64'h010401040104);
        chk("t3_ids", pack(id_log), 64'h000200020002);
        chk("t3_rx", pack(rx_q), 64'h5AC35AC35AC3);

        // busy never rises: watchdog fires, then a normal transfer
        clr();
        tx_en = 0; req_data = 32'h0000_E100; req = 4'b0010;
        run(BT + 8);
        chk("t4_timeout_cnt", 64'(to_cnt), 1);
        chk("t4_timeout_delay", 64'(to_cyc - tx_cyc), 64'(BT + 1));
        chk("t4_no_done", 64'(d_log.size()), 0);
        tx_en = 1; req_data = 32'h7700_0000; req = 4'b1000;
        run(12);
        chk("t4_grants", pack(g_log), 64'h0208);
        chk("t4_rx", pack(rx_q), 64'h77);
        chk("t4_done", pack(d_log), 64'h08);

        // asynchronous reset during WAIT_END
        clr();
        req_data = 32'h0000_0099; req = 4'b0001;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        chk("t5_busy_seen", 64'(busy), 1);
        tick();
        #2 reset = 1'b0; model_reset();
        #1 check();
        chk("t5_arb_busy", 64'(arb_busy), 0);
        chk("t5_TxData", 64'(TxData), 0);
        chk("t5_done", 64'(done), 0);
        run(3);
        clr();
        reset = 1'b1; req_data = 32'h3400_0012; req = 4'b1001;
        run(25);
        chk("t5_grants", pack(g_log), 64'h0108);
        chk("t5_txdata", pack(gd_log), 64'h1234);
        chk("t5_done", pack(d_log), 64'h0108);

        // request raised while the transmitter is busy
        clr();
        req_data = 32'h0000_6600; req = 4'b0010;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        req_data = 32'h0055_6600; req[2] = 1'b1;
        run(22);
        chk("t6_grants", pack(g_log), 64'h0204);
        chk("t6_late_grant", 64'(g_cyc.size() == 2 && d_cyc.size() > 0 ? g_cyc[1] - d_cyc[0] : -1), 1);
        chk("t6_rx", pack(rx_q), 64'h6655);
        chk("t6_done", pack(d_log), 64'h0204);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one Uart_Transmitter among NUM_REQ byte requesters using round-robin arbitration.
It captures the winning requester's byte and issues the single-cycle transmit pulse with TxData. It then tracks the transmitter's busy to completion and returns a per-requester done pulse.
A timeout watchdog recovers if the transmitter never asserts busy.
It sits between the client logic and Uart_Transmitter; TxD and RxD are untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, width of active_id; NUM_REQ <= 2**ID_W required.
DATA_W, 8, byte width, matching the transmitter's TxData.
BUSY_TIMEOUT, 16, cycles to wait in WAIT_START for busy=1 before aborting (>=2).

Ports:
clk  input  1  system clock, all state on posedge.
reset  input  1  asynchronous, active-low; 0 clears all state immediately.
req  input  NUM_REQ  per-requester send request, level.
req_data  input  NUM_REQ*DATA_W  byte for requester i at bits [i*DATA_W +: DATA_W].
grant  output  NUM_REQ  one-hot, 1-cycle pulse: byte from that requester accepted.
done  output  NUM_REQ  one-hot, 1-cycle pulse: that requester's byte fully transmitted.
transmit  output  1  to Uart_Transmitter.transmit, 1-cycle pulse.
TxData  output  DATA_W  to Uart_Transmitter.TxData.
busy  input  1  from Uart_Transmitter.busy.
active_id  output  ID_W  index of the current or last granted requester.
arb_busy  output  1  1 whenever state != IDLE.
timeout_err  output  1  1-cycle pulse on a busy-start timeout.

Behaviour:
- All outputs are registered.
- Reset (reset=0, async) sets state=IDLE and clears transmit, TxData, grant, done, active_id, timeout_err and timer to 0. It sets last_id=NUM_REQ-1, so req[0] has highest priority first.
- Reset mid-operation aborts the transfer with no done and no error. The transmitter is reset by its own reset.
- States: IDLE, LAUNCH, WAIT_START, WAIT_END.
- IDLE, when req!=0 and busy=0: select the first asserted req scanning from (last_id+1) mod NUM_REQ upward with wrap-around. On the next edge:
  - state<=LAUNCH
  - transmit<=1
  - TxData<=req_data[sel]
  - grant<=onehot(sel)
  - active_id<=sel
  - last_id<=sel
- IDLE, when req=0 or busy=1: remain in IDLE with no grant.
- LAUNCH lasts 1 cycle; grant and transmit are high only here. Next edge: transmit<=0, grant<=0, timer<=0, state<=WAIT_START.
- WAIT_START:
  - If busy=1, go to WAIT_END.
  - Otherwise timer++.
  - When timer==BUSY_TIMEOUT-1 and busy=0: timeout_err<=1 for 1 cycle, state<=IDLE, no done.
- WAIT_END: when busy=0, state<=IDLE and done[active_id]<=1 for 1 cycle.
- Latency:
  - req to grant/transmit is 1 cycle from IDLE.
  - busy falling to done is 1 cycle.
  - Arbitration runs during the done cycle, so back-to-back transfers have no extra idle cycle.
- Requester rules:
  - Hold req and req_data stable until grant is seen.
  - Deassert req in the cycle after grant unless another byte is queued.
  - A req still high at the next arbitration is treated as a new byte.
- Ignored inputs: req changes outside IDLE have no effect, and data is captured only at the IDLE to LAUNCH edge.
- TxData holds its value until the next launch.
- A single requester may be granted consecutively if no other req is asserted.

Test Plan:
1. Single transfer with loopback: req=4'b0001, req_data[7:0]=8'hA5.
   - grant=0001 and transmit=1 for exactly 1 cycle, TxData=A5.
   - done=0001 one cycle after busy falls; receiver RxData=A5 with valid_rx.
2. Simultaneous requests: req=4'b1111 with data 11,22,33,44, each req dropped after its grant.
   - Grants occur in order 0,1,2,3 and RxData sequence is 11,22,33,44.
   - Exactly 4 done pulses; transmit is never asserted while busy=1.
3. Fairness: req[0] and req[2] continuously re-requested with data 5A and C3.
   - Grants alternate 0,2,0,2 for 6 transfers; active_id matches each grant.
4. Timeout: busy forced to 0 and req=0010.
   - timeout_err pulses exactly BUSY_TIMEOUT+1 cycles after the transmit pulse; no done[1].
   - A subsequent req[3] with busy released is served normally.
5. Reset mid-transfer: reset=0 during WAIT_END.
   - All outputs read 0 before the next clk edge and no done is issued.
   - After release, with req=1001, req[0] is granted first.
6. Late request: req asserted while busy=1 from an earlier transfer.
   - No grant until busy=0 and state=IDLE; grant follows on the edge after done.
